// File: rtl/video_dnn_argmax_vote.sv
// video_dnn_argmax_vote
//   Per-pixel argmax over DNN class scores carried on AXI4-Stream, with a
//   runtime confidence threshold and per-frame class voting. Frame results
//   (winner, per-class vote snapshot, frame count) are read over Wishbone.
//
// Ports
//   aclk, areset        single clock, async active-high reset
//   s_axi4s_*           input beats: tdata holds NUM_CLASS unsigned scores,
//                       class i at [i*CHANNEL_WIDTH +: CHANNEL_WIDTH]; tuser[0] = frame start
//   m_axi4s_*           output beats, two beats behind the input: winning class
//                       (or NUM_CLASS when the max is below threshold), max score,
//                       and the delayed tuser/tlast/tdata
//   s_wb_*              zero-wait Wishbone register file, combinational reads
module video_dnn_argmax_vote #(
  parameter int NUM_CLASS     = 10,
  parameter int CHANNEL_WIDTH = 8,
  parameter int TUSER_WIDTH   = 1,
  parameter int TNUMBER_WIDTH = 4,
  parameter int VOTE_WIDTH    = 20,
  parameter int WB_ADR_WIDTH  = 8,
  parameter int WB_DAT_WIDTH  = 32,
  parameter int INIT_TH       = 0
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic [TUSER_WIDTH-1:0]               s_axi4s_tuser,
  input  logic                                 s_axi4s_tlast,
  input  logic [NUM_CLASS*CHANNEL_WIDTH-1:0]   s_axi4s_tdata,
  input  logic                                 s_axi4s_tvalid,
  output logic                                 s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]               m_axi4s_tuser,
  output logic                                 m_axi4s_tlast,
  output logic [TNUMBER_WIDTH-1:0]             m_axi4s_tnumber,
  output logic [CHANNEL_WIDTH-1:0]             m_axi4s_tcount,
  output logic [NUM_CLASS*CHANNEL_WIDTH-1:0]   m_axi4s_tdata,
  output logic                                 m_axi4s_tvalid,
  input  logic                                 m_axi4s_tready,
  input  logic [WB_ADR_WIDTH-1:0]              s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]              s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]              s_wb_dat_o,
  input  logic                                 s_wb_we_i,
  input  logic [WB_DAT_WIDTH/8-1:0]            s_wb_sel_i,
  input  logic                                 s_wb_stb_i,
  output logic                                 s_wb_ack_o
);

  localparam int CW = CHANNEL_WIDTH;
  localparam int DW = NUM_CLASS * CHANNEL_WIDTH;
  localparam logic [TNUMBER_WIDTH-1:0] NONE = TNUMBER_WIDTH'(NUM_CLASS);

  localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_ID   = WB_ADR_WIDTH'(8'h00);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_CONTROL   = WB_ADR_WIDTH'(8'h01);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_PARAM_TH  = WB_ADR_WIDTH'(8'h04);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_TH_ACT    = WB_ADR_WIDTH'(8'h05);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_WINNER    = WB_ADR_WIDTH'(8'h08);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_FRAME_CNT = WB_ADR_WIDTH'(8'h09);
  localparam int                      ADR_VOTE_BASE = 16;

  logic                     cke;
  logic                     in_sof;
  logic                     out_acc;
  logic                     out_sof;

  logic                     st0_valid;
  logic [TUSER_WIDTH-1:0]   st0_user;
  logic                     st0_last;
  logic [DW-1:0]            st0_data;

  logic [CW-1:0]            max_score;
  logic [TNUMBER_WIDTH-1:0] max_idx;

  logic [CW-1:0]            th_reg;
  logic [CW-1:0]            th_act;
  logic                     upd_req;
  logic                     wb_wr;
  logic                     th_wr;
  logic                     ctl_set;

  logic [VOTE_WIDTH-1:0]    vote [NUM_CLASS];
  logic [VOTE_WIDTH-1:0]    snap [NUM_CLASS];
  logic [NUM_CLASS-1:0]     vote_hit;
  logic [VOTE_WIDTH-1:0]    vote_max;
  logic [TNUMBER_WIDTH-1:0] vote_idx;
  logic [TNUMBER_WIDTH-1:0] win_next;
  logic [TNUMBER_WIDTH-1:0] winner;
  logic [31:0]              frame_cnt;

  // Only some data/select bits are meaningful for any given register.
  logic unused_wb;
  assign unused_wb = ^{s_wb_dat_i, s_wb_sel_i};

  // Both stages advance together; a stalled output freezes the whole pipe.
  assign cke            = ~m_axi4s_tvalid | m_axi4s_tready;
  assign s_axi4s_tready = cke;
  assign in_sof         = s_axi4s_tvalid & cke & s_axi4s_tuser[0];
  assign out_acc        = m_axi4s_tvalid & m_axi4s_tready;
  assign out_sof        = out_acc & m_axi4s_tuser[0];

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    max_score = st0_data[0 +: CW];
    max_idx   = '0;
    for (int i = 1; i < NUM_CLASS; i++) begin
      if (st0_data[i*CW +: CW] > max_score) begin
        max_score = st0_data[i*CW +: CW];
        max_idx   = TNUMBER_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      st0_valid       <= 1'b0;
      st0_user        <= '0;
      st0_last        <= 1'b0;
      st0_data        <= '0;
      m_axi4s_tvalid  <= 1'b0;
      m_axi4s_tuser   <= '0;
      m_axi4s_tlast   <= 1'b0;
      m_axi4s_tdata   <= '0;
      m_axi4s_tcount  <= '0;
      m_axi4s_tnumber <= '0;
    end else if (cke) begin
      st0_valid       <= s_axi4s_tvalid;
      st0_user        <= s_axi4s_tuser;
      st0_last        <= s_axi4s_tlast;
      st0_data        <= s_axi4s_tdata;
      m_axi4s_tvalid  <= st0_valid;
      m_axi4s_tuser   <= st0_user;
      m_axi4s_tlast   <= st0_last;
      m_axi4s_tdata   <= st0_data;
      m_axi4s_tcount  <= max_score;
      m_axi4s_tnumber <= (max_score < th_act) ? NONE : max_idx;
    end
  end

  // Threshold is shadowed: software writes th_reg, and th_act only follows on
  // a frame-start input beat, so a frame never sees a mid-frame change. The
  // frame-start beat sits in st0 after that edge, so it already uses th_act.
  assign wb_wr   = s_wb_stb_i & s_wb_we_i;
  assign th_wr   = wb_wr & (s_wb_adr_i == ADR_PARAM_TH);
  assign ctl_set = wb_wr & (s_wb_adr_i == ADR_CONTROL) & s_wb_sel_i[0] & s_wb_dat_i[0];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      th_reg  <= CW'(INIT_TH);
      th_act  <= CW'(INIT_TH);
      upd_req <= 1'b0;
    end else begin
      if (th_wr) begin
        for (int b = 0; b < CW; b++) begin
          if (s_wb_sel_i[b/8]) th_reg[b] <= s_wb_dat_i[b];
        end
      end
      if (in_sof && upd_req) th_act <= th_reg;
      // A set landing on the frame-start edge is kept for the next frame.
      if (ctl_set)     upd_req <= 1'b1;
      else if (in_sof) upd_req <= 1'b0;
    end
  end

  always_comb begin
    vote_hit = '0;
    for (int i = 0; i < NUM_CLASS; i++) begin
      vote_hit[i] = out_acc && (m_axi4s_tnumber == TNUMBER_WIDTH'(i));
    end
  end

  // Winner of the frame that is closing: argmax of the pre-beat votes.
  always_comb begin
    vote_max = vote[0];
    vote_idx = '0;
    for (int i = 1; i < NUM_CLASS; i++) begin
      if (vote[i] > vote_max) begin
        vote_max = vote[i];
        vote_idx = TNUMBER_WIDTH'(i);
      end
    end
    win_next = (vote_max == '0) ? NONE : vote_idx;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_CLASS; i++) begin
        vote[i] <= '0;
        snap[i] <= '0;
      end
      winner    <= NONE;
      frame_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CLASS; i++) begin
        if (out_sof) begin
          snap[i] <= vote[i];
          vote[i] <= vote_hit[i] ? VOTE_WIDTH'(1) : '0;
        end else if (vote_hit[i] && (vote[i] != '1)) begin
          vote[i] <= vote[i] + VOTE_WIDTH'(1);
        end
      end
      if (out_sof) begin
        winner    <= win_next;
        frame_cnt <= frame_cnt + 32'd1;
      end
    end
  end

  assign s_wb_ack_o = s_wb_stb_i;

  always_comb begin
    s_wb_dat_o = '0;
    case (s_wb_adr_i)
      ADR_CORE_ID:   s_wb_dat_o = WB_DAT_WIDTH'(32'h5A5A_0D17);
      ADR_CONTROL:   s_wb_dat_o = WB_DAT_WIDTH'(upd_req);
      ADR_PARAM_TH:  s_wb_dat_o = WB_DAT_WIDTH'(th_reg);
      ADR_TH_ACT:    s_wb_dat_o = WB_DAT_WIDTH'(th_act);
      ADR_WINNER:    s_wb_dat_o = WB_DAT_WIDTH'(winner);
      ADR_FRAME_CNT: s_wb_dat_o = WB_DAT_WIDTH'(frame_cnt);
      default: begin
        for (int i = 0; i < NUM_CLASS; i++) begin
          if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_VOTE_BASE + i)) s_wb_dat_o = WB_DAT_WIDTH'(snap[i]);
        end
      end
    endcase
  end

endmodule
